// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD request arbiter.
// The optional grant-cycle counters are enabled with SD_ARB_PERF_EN.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } sd_arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/sd_req_arbiter_rr_pick.sv
// One-hot picker: returns the first set request at or after i_base, wrapping to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_base,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW-1:0] w_pos;

  // Scan from the farthest offset down so the nearest match is written last.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = IW'((int'(i_base) + k) % N);
      if (i_req[w_pos]) begin
        o_gnt        = '0;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
        o_valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_req_arbiter.sv
// Shares one sdspihost among N_CH read requesters; a grant is held for a whole SD transaction.
// Define SD_ARB_PERF_EN to add per-channel saturating grant-cycle counters (perf_clr / perf_cycles).
module sd_req_arbiter
  import sd_arb_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int ADDR_W   = 32,
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          req_r_block,
  input  logic [N_CH-1:0]          req_r_multi_block,
  input  logic [N_CH-1:0]          req_r_byte,
  input  logic [N_CH*ADDR_W-1:0]   req_block_addr,
  output logic                     spi_r_block,
  output logic                     spi_r_multi_block,
  output logic                     spi_r_byte,
  output logic [ADDR_W-1:0]        spi_block_addr,
  input  logic                     spi_busy,
  input  logic                     spi_err,
`ifdef SD_ARB_PERF_EN
  input  logic                     perf_clr,
  output logic [N_CH*64-1:0]       perf_cycles,
`endif
  output logic [N_CH-1:0]          ch_busy,
  output logic [N_CH-1:0]          ch_err,
  output logic [N_CH-1:0]          gnt,
  output logic [$clog2(N_CH)-1:0]  active_ch
);

  localparam int IW = $clog2(N_CH);

  sd_arb_state_t     r_state;
  sd_arb_state_t     w_state_next;
  logic [N_CH-1:0]   r_gnt;
  logic [IW-1:0]     r_win;
  logic [IW-1:0]     r_rr_ptr;
  logic [IW-1:0]     w_ptr_next;
  logic [IW-1:0]     w_base;
  logic [N_CH-1:0]   w_req;
  logic [N_CH-1:0]   w_pick_gnt;
  logic [IW-1:0]     w_pick_idx;
  logic              w_pick_valid;
  logic              w_win_req;
  logic [ADDR_W-1:0] w_addr_masked [N_CH];
  logic [ADDR_W-1:0] w_addr_or;

  assign w_req      = req_r_block | req_r_multi_block;
  assign w_win_req  = |(w_req & r_gnt);
  assign w_base     = (ARB_MODE == ARB_RR) ? r_rr_ptr : '0;
  assign w_ptr_next = (r_win == IW'(N_CH - 1)) ? '0 : r_win + 1'b1;

  rr_pick #(
    .N  (N_CH),
    .IW (IW)
  ) u_pick (
    .i_req   (w_req),
    .i_base  (w_base),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Busy is checked first in GRANT: once the host starts, a dropped request cannot abort.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_pick_valid) w_state_next = GRANT;
      GRANT: begin
        if (spi_busy)        w_state_next = ACTIVE;
        else if (!w_win_req) w_state_next = RELEASE;
      end
      ACTIVE:  if (!spi_busy && !w_win_req) w_state_next = RELEASE;
      RELEASE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Grant drops on entry to RELEASE, giving RELEASE + IDLE as two grant-free cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_win    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_pick_valid) begin
        r_gnt <= w_pick_gnt;
        r_win <= w_pick_idx;
      end else if (w_state_next == RELEASE && r_state != RELEASE) begin
        r_gnt    <= '0;
        r_win    <= '0;
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_addr_masked[gi] = req_block_addr[gi*ADDR_W +: ADDR_W] & {ADDR_W{r_gnt[gi]}};
      assign ch_busy[gi]       = r_gnt[gi] ? spi_busy : 1'b1;
      assign ch_err[gi]        = spi_err & r_gnt[gi];
    end
  endgenerate

  always_comb begin
    w_addr_or = '0;
    for (int i = 0; i < N_CH; i++) w_addr_or = w_addr_or | w_addr_masked[i];
  end

  assign spi_r_block       = |(req_r_block & r_gnt);
  assign spi_r_multi_block = |(req_r_multi_block & r_gnt);
  assign spi_r_byte        = |(req_r_byte & r_gnt);
  assign spi_block_addr    = w_addr_or;
  assign gnt               = r_gnt;
  assign active_ch         = r_win;

`ifdef SD_ARB_PERF_EN
  logic w_tenure;
  assign w_tenure = (r_state == GRANT) || (r_state == ACTIVE);

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_perf
      logic [63:0] r_perf;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   r_perf <= '0;
        else if (perf_clr)                            r_perf <= '0;
        else if (r_gnt[gi] && w_tenure && !(&r_perf)) r_perf <= r_perf + 64'd1;
      end
      assign perf_cycles[gi*64 +: 64] = r_perf;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Bench for sd_req_arbiter: a fixed-priority and a round-robin instance share stimulus and are
// compared every cycle against an owner/gap/pointer model, plus directed vectors and sequences.
module tb_sd_req_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_blk = '0;
  logic [3:0]   req_multi = '0;
  logic [3:0]   req_byte = '0;
  logic [127:0] req_addr = '0;
  logic         spi_busy = 1'b0;
  logic         spi_err = 1'b0;

  logic [3:0]   o_gnt  [2];
  logic [3:0]   o_busy [2];
  logic [3:0]   o_err  [2];
  logic [1:0]   o_act  [2];
  logic         o_blk  [2];
  logic         o_multi[2];
  logic         o_byte [2];
  logic [31:0]  o_addr [2];
`ifdef SD_ARB_PERF_EN
  logic         perf_clr = 1'b0;
  logic [255:0] o_perf [2];
`endif

  int checks = 0;
  int errors = 0;
  int m_owner[2];
  int m_gap[2];
  int m_ptr[2];
  int byte_cnt[2];
  int idle_cnt;

  always #5 clk = ~clk;

  sd_req_arbiter #(.N_CH(4), .ADDR_W(32), .ARB_MODE(0)) dut_fix (
    .clk(clk), .rst_n(rst_n),
    .req_r_block(req_blk), .req_r_multi_block(req_multi), .req_r_byte(req_byte),
    .req_block_addr(req_addr),
    .spi_r_block(o_blk[0]), .spi_r_multi_block(o_multi[0]), .spi_r_byte(o_byte[0]),
    .spi_block_addr(o_addr[0]), .spi_busy(spi_busy), .spi_err(spi_err),
`ifdef SD_ARB_PERF_EN
    .perf_clr(perf_clr), .perf_cycles(o_perf[0]),
`endif
    .ch_busy(o_busy[0]), .ch_err(o_err[0]), .gnt(o_gnt[0]), .active_ch(o_act[0])
  );

  sd_req_arbiter #(.N_CH(4), .ADDR_W(32), .ARB_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req_r_block(req_blk), .req_r_multi_block(req_multi), .req_r_byte(req_byte),
    .req_block_addr(req_addr),
    .spi_r_block(o_blk[1]), .spi_r_multi_block(o_multi[1]), .spi_r_byte(o_byte[1]),
    .spi_block_addr(o_addr[1]), .spi_busy(spi_busy), .spi_err(spi_err),
`ifdef SD_ARB_PERF_EN
    .perf_clr(perf_clr), .perf_cycles(o_perf[1]),
`endif
    .ch_busy(o_busy[1]), .ch_err(o_err[1]), .gnt(o_gnt[1]), .active_ch(o_act[1])
  );

  typedef struct packed {
    logic [3:0]  blk;
    logic        busy;
    logic        err;
    logic [3:0]  g;
    logic [3:0]  b;
    logic [3:0]  e;
    logic [31:0] ad;
  } vec_t;

  vec_t tbl[13];
  int   ord[5];

  // ---------------- reference model ----------------
  function automatic int pick(int m);
    logic [3:0] w;
    int base;
    w    = req_blk | req_multi;
    base = (m == 1) ? m_ptr[m] : 0;
    for (int k = 0; k < 4; k++) begin
      if (w[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1;
      m_gap[m]   = 0;
      m_ptr[m]   = 0;
    end
  endtask

  task automatic model_step();
    logic [3:0] w;
    w = req_blk | req_multi;
    for (int m = 0; m < 2; m++) begin
      if (m_owner[m] < 0) begin
        if (m_gap[m] > 0) m_gap[m]--;
        else if (w != 4'd0) m_owner[m] = pick(m);
      end else if (!spi_busy && !w[m_owner[m]]) begin
        m_ptr[m]   = (m_owner[m] + 1) % 4;
        m_owner[m] = -1;
        m_gap[m]   = 1;
      end
    end
  endtask

  function automatic logic [63:0] exp_vec(int m);
    logic [3:0]  g, b, e;
    logic [1:0]  a;
    logic        sb, sm, sy;
    logic [31:0] ad;
    g = '0; b = 4'hF; e = '0; a = '0; sb = 1'b0; sm = 1'b0; sy = 1'b0; ad = '0;
    if (m_owner[m] >= 0) begin
      int o;
      o     = m_owner[m];
      g     = 4'(1) << o;
      a     = 2'(o);
      sb    = req_blk[o];
      sm    = req_multi[o];
      sy    = req_byte[o];
      ad    = req_addr[o*32 +: 32];
      b[o]  = spi_busy;
      e[o]  = spi_err;
    end
    return {15'd0, g, a, sb, sm, sy, ad, b, e};
  endfunction

  function automatic logic [63:0] act_vec(int m);
    return {15'd0, o_gnt[m], o_act[m], o_blk[m], o_multi[m], o_byte[m], o_addr[m], o_busy[m], o_err[m]};
  endfunction

  task automatic chk(string nm, int m, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, m, act, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("outputs", m, act_vec(m), exp_vec(m));
      if (o_byte[m] === 1'b1) byte_cnt[m]++;
    end
    if (o_gnt[1] == 4'd0) idle_cnt++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_grant(int m, string nm);
    for (int n = 0; n < 12 && m_owner[m] < 0; n++) cycle();
    if (m_owner[m] < 0) begin
      checks++;
      errors++;
      $display("FAIL %s dut%0d: no grant within 12 cycles", nm, m);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_blk   = '0;
    req_multi = '0;
    req_byte  = '0;
    spi_busy  = 1'b0;
    spi_err   = 1'b0;
`ifdef SD_ARB_PERF_EN
    perf_clr  = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    for (int m = 0; m < 2; m++) chk("reset", m, act_vec(m), exp_vec(m));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 32'h0};
    tbl[1]  = '{4'b0101, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 32'h0};
    tbl[2]  = '{4'b0101, 1'b0, 1'b0, 4'b0001, 4'b1110, 4'b0000, 32'hA000_0000};
    tbl[3]  = '{4'b0101, 1'b1, 1'b0, 4'b0001, 4'b1111, 4'b0000, 32'hA000_0000};
    tbl[4]  = '{4'b0101, 1'b1, 1'b0, 4'b0001, 4'b1111, 4'b0000, 32'hA000_0000};
    tbl[5]  = '{4'b0100, 1'b1, 1'b0, 4'b0001, 4'b1111, 4'b0000, 32'hA000_0000};
    tbl[6]  = '{4'b0100, 1'b0, 1'b0, 4'b0001, 4'b1110, 4'b0000, 32'hA000_0000};
    tbl[7]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 32'h0};
    tbl[8]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 32'h0};
    tbl[9]  = '{4'b0100, 1'b0, 1'b0, 4'b0100, 4'b1011, 4'b0000, 32'hC222_0002};
    tbl[10] = '{4'b0100, 1'b1, 1'b1, 4'b0100, 4'b1111, 4'b0100, 32'hC222_0002};
    tbl[11] = '{4'b0000, 1'b0, 1'b0, 4'b0100, 4'b1011, 4'b0000, 32'hC222_0002};
    tbl[12] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 32'h0};
    ord = '{0, 1, 2, 3, 0};
    byte_cnt = '{0, 0};
    idle_cnt = 0;

    // Directed vectors: simultaneous ch0/ch2 requests, ch2 waits out ch0's tenure.
    do_reset();
    req_addr = {32'hD333_0003, 32'hC222_0002, 32'hB111_0001, 32'hA000_0000};
    for (int i = 0; i < 13; i++) begin
      req_blk  = tbl[i].blk;
      spi_busy = tbl[i].busy;
      spi_err  = tbl[i].err;
      #1;
      for (int m = 0; m < 2; m++) begin
        chk("tbl_gnt",  m, 64'(o_gnt[m]),  64'(tbl[i].g));
        chk("tbl_busy", m, 64'(o_busy[m]), 64'(tbl[i].b));
        chk("tbl_err",  m, 64'(o_err[m]),  64'(tbl[i].e));
        chk("tbl_addr", m, 64'(o_addr[m]), 64'(tbl[i].ad));
      end
      cycle();
    end

    // Round robin with every channel requesting: order 0,1,2,3,0 and two grant-free cycles.
    do_reset();
    req_blk = 4'hF;
    for (int t = 0; t < 5; t++) begin
      idle_cnt = 0;
      wait_grant(1, "rr_grant");
      chk("rr_order", 1, 64'(o_gnt[1]), 64'(4'(1) << ord[t]));
      if (t > 0) chk("rr_gap", 1, 64'(idle_cnt), 64'd2);
      spi_busy = 1'b1;
      repeat (3) cycle();
      spi_busy = 1'b0;
      req_blk[ord[t]] = 1'b0;
      cycle();
      req_blk = 4'hF;
    end

    // Ch1 multi-block read: 4 blocks x 512 byte strobes, busy drops between blocks.
    do_reset();
    req_multi = 4'b0010;
    wait_grant(0, "multi_grant");
    wait_grant(1, "multi_grant");
    byte_cnt = '{0, 0};
    for (int b = 0; b < 4; b++) begin
      spi_busy = 1'b1;
      for (int k = 0; k < 1024; k++) begin
        req_byte = (k % 2 == 1) ? 4'b0010 : 4'b0000;
        cycle();
      end
      req_byte = '0;
      spi_busy = 1'b0;
      repeat (2) cycle();
    end
    req_multi = '0;
    repeat (3) cycle();
    for (int m = 0; m < 2; m++) begin
      chk("byte_pulses", m, 64'(byte_cnt[m]), 64'd2048);
      chk("multi_release", m, 64'(o_gnt[m]), 64'd0);
    end

    // Ch3 aborts before busy; RR pointer must wrap to 0, so ch0 beats ch2 next.
    req_blk = 4'b1000;
    wait_grant(1, "abort_grant");
    chk("abort_gnt", 1, 64'(o_gnt[1]), 64'h8);
    req_blk = 4'b0000;
    repeat (3) cycle();
    req_blk = 4'b0101;
    wait_grant(1, "wrap_grant");
    chk("rr_ptr_wrap", 1, 64'(o_gnt[1]), 64'h1);
    req_blk = 4'b0000;
    repeat (3) cycle();

    // Asynchronous reset in the middle of ch2's tenure.
    req_blk = 4'b0100;
    wait_grant(0, "rst_grant");
    wait_grant(1, "rst_grant");
    spi_busy = 1'b1;
    spi_err  = 1'b1;
    repeat (2) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int m = 0; m < 2; m++) chk("async_rst", m, act_vec(m), exp_vec(m));
    req_blk  = '0;
    spi_busy = 1'b0;
    spi_err  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_step();
    #1;

`ifdef SD_ARB_PERF_EN
    // Ch0 holds the grant for exactly 100 cycles.
    do_reset();
    req_blk = 4'b0001;
    wait_grant(0, "perf_grant");
    for (int k = 1; k <= 100; k++) begin
      if (k == 100) req_blk = 4'b0000;
      cycle();
    end
    cycle();
    for (int m = 0; m < 2; m++) begin
      chk("perf_ch0", m, o_perf[m][63:0], 64'd100);
      chk("perf_others", m, 64'(|o_perf[m][255:64]), 64'd0);
    end
    perf_clr = 1'b1;
    cycle();
    perf_clr = 1'b0;
    for (int m = 0; m < 2; m++) chk("perf_clr", m, 64'(|o_perf[m]), 64'd0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(15) == 0) req_blk[i]   = ~req_blk[i];
        if ($urandom_range(31) == 0) req_multi[i] = ~req_multi[i];
        if ($urandom_range(63) == 0) req_addr[i*32 +: 32] = $urandom;
      end
      req_byte = 4'($urandom);
      if ($urandom_range(3) == 0) spi_busy = ~spi_busy;
      spi_err = ($urandom_range(7) == 0);
      cycle();
    end
    req_blk   = '0;
    req_multi = '0;
    req_byte  = '0;
    spi_busy  = 1'b0;
    spi_err   = 1'b0;
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
